// File: rtl/alu_cmd_sequencer.sv
// Single-issue command sequencer driving an external ALU from an 8-entry register file.
// Optional SEQ_PERF_CNT_EN adds retired_cnt / abort_cnt performance counters.
module alu_cmd_sequencer #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       cmd_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_start,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic              cmd_done,
    output logic              cmd_err,
`ifdef SEQ_PERF_CNT_EN
    output logic [15:0]       retired_cnt,
    output logic [7:0]        abort_cnt,
`endif
    output logic [DATA_W-1:0] result_out
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_ABORT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]        f_instr;
    logic [2:0]        f_dst;
    logic [2:0]        f_srca;
    logic [2:0]        f_srcb;
    logic [DATA_W-1:0] f_imm;
    logic              accept;
    logic              is_ldi;

    logic [2:0]        dst;
    logic [DATA_W-1:0] res;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rf [8];

    assign f_instr = cmd_in[11:9];
    assign f_dst   = cmd_in[8:6];
    assign f_srca  = cmd_in[5:3];
    assign f_srcb  = cmd_in[2:0];
    assign f_imm   = DATA_W'({f_srca, f_srcb});
    assign accept  = cmd_valid && cmd_ready;
    assign is_ldi  = (f_instr == OP_LDI);

    // State register; reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; LDI bypasses the ALU entirely.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = is_ldi ? S_WB : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    state_nxt = S_WB;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_ABORT;
                end
            end
            S_WB: begin
                state_nxt = S_IDLE;
            end
            S_ABORT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs are pure functions of state.
    always_comb begin
        cmd_ready = 1'b0;
        alu_start = 1'b0;
        cmd_done  = 1'b0;
        cmd_err   = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_ISSUE: begin
                alu_start = 1'b1;
            end
            S_WAIT: begin
                alu_start = 1'b0;
            end
            S_WB: begin
                cmd_done = 1'b1;
            end
            S_ABORT: begin
                cmd_done = 1'b1;
                cmd_err  = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Capture operands at acceptance so a destination may alias a source.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            dst    <= '0;
        end else if (accept) begin
            alu_op <= f_instr;
            alu_a  <= rf[f_srca];
            alu_b  <= rf[f_srcb];
            dst    <= f_dst;
        end
    end

    // WAIT-cycle counter, cleared while the start pulse is out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= '0;
        end else if (state == S_WAIT && !alu_done) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending write-back value: immediate for LDI, ALU result otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            res <= '0;
        end else if (accept && is_ldi) begin
            res <= f_imm;
        end else if (state == S_WAIT && alu_done) begin
            res <= alu_result;
        end
    end

    // Register file and result_out update only on a successful retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
            result_out <= '0;
        end else if (state == S_WB) begin
            rf[dst]    <= res;
            result_out <= res;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Retire counter wraps; abort counter sticks at its maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= '0;
            abort_cnt   <= '0;
        end else begin
            if (state == S_WB) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
            if (state == S_ABORT && abort_cnt != 8'hFF) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a latency-programmable ALU model.
// Define SEQ_PERF_CNT_EN to also check the performance counters.
module tb_alu_cmd_sequencer;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [11:0]   cmd_in;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_start;
    logic [DW-1:0] alu_result = '0;
    logic          alu_done = 1'b0;
    logic          cmd_done;
    logic          cmd_err;
    logic [DW-1:0] result_out;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]   retired_cnt;
    logic [7:0]    abort_cnt;
`endif

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_in     (cmd_in),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_start  (alu_start),
        .alu_result (alu_result),
        .alu_done   (alu_done),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
`ifdef SEQ_PERF_CNT_EN
        .retired_cnt(retired_cnt),
        .abort_cnt  (abort_cnt),
`endif
        .result_out (result_out)
    );

    typedef struct {
        logic          err;
        logic [DW-1:0] res;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;
        int            starts;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [DW-1:0] mrf [8];
    logic [DW-1:0] last_res;
    int            ret_exp = 0;
    int            ab_exp = 0;
    int            alu_lat = 1;
    bit            alu_en = 1'b1;
    bit            glitch = 1'b0;
    bit            apend = 1'b0;
    int            acnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] alu_fn(input logic [2:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            default: return b;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: done alu_lat cycles after the start pulse; optional junk done during ISSUE.
    always @(negedge clk) begin
        if (alu_start && alu_en) begin
            apend    <= 1'b1;
            acnt     <= alu_lat;
            alu_done <= glitch;
            if (glitch) alu_result <= 8'hEE;
        end else if (apend && acnt == 1) begin
            apend      <= 1'b0;
            alu_done   <= 1'b1;
            alu_result <= alu_fn(alu_op, alu_a, alu_b);
        end else if (apend) begin
            acnt     <= acnt - 1;
            alu_done <= 1'b0;
        end else begin
            alu_done <= 1'b0;
        end
    end

    bit            busy = 1'b0;
    bit            pres = 1'b0;
    logic [DW-1:0] pres_v;
    int            starts = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            busy   = 1'b0;
            pres   = 1'b0;
            starts = 0;
        end else begin
            if (pres) begin
                check("result_out", result_out, pres_v);
                pres = 1'b0;
            end
            check("cmd_ready", cmd_ready, !busy);
            if (alu_start) begin
                starts++;
                if (sb.size() > 0) begin
                    check("alu_a", alu_a, sb[0].a);
                    check("alu_b", alu_b, sb[0].b);
                end
            end
            if (cmd_done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", cmd_done, 0);
                end else begin
                    e = sb.pop_front();
                    check("cmd_err", cmd_err, e.err);
                    check("latency", cyc - e.acc, e.lat);
                    check("start_pulses", starts, e.starts);
                    if (e.starts != 0) begin
                        check("alu_a_hold", alu_a, e.a);
                        check("alu_b_hold", alu_b, e.b);
                    end
                    pres   = 1'b1;
                    pres_v = e.res;
                end
                starts = 0;
                busy   = 1'b0;
            end else begin
                check("cmd_err_idle", cmd_err, 0);
            end
            if (cmd_valid && cmd_ready) busy = 1'b1;
        end
    end

    function automatic void push(input logic [11:0] c, input int acc);
        exp_t e;
        logic [2:0] op, d, a, b;
        {op, d, a, b} = c;
        e.acc = acc;
        e.err = 1'b0;
        e.a   = mrf[a];
        e.b   = mrf[b];
        if (op == 3'b111) begin
            e.res    = {2'b00, a, b};
            e.lat    = 1;
            e.starts = 0;
        end else begin
            e.starts = 1;
            if (alu_en) begin
                e.res = alu_fn(op, mrf[a], mrf[b]);
                e.lat = alu_lat + 2;
            end else begin
                e.err = 1'b1;
                e.res = last_res;
                e.lat = TO + 2;
            end
        end
        if (!e.err) begin
            mrf[d]   = e.res;
            last_res = e.res;
            ret_exp++;
        end else begin
            ab_exp++;
        end
        sb.push_back(e);
    endfunction

    task automatic send(input logic [11:0] c, input bit track);
        int w = 0;
        cmd_in    = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) check("accept_timeout", cmd_ready, 1);
        else if (track) push(c, cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        cmd_valid = 1'b0;
        while (sb.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        last_res = '0;
        ret_exp  = 0;
        ab_exp   = 0;
    endtask

    initial begin
        logic [2:0] op, d, a, b;
        int seen;
        reset     = 1'b1;
        cmd_in    = '0;
        cmd_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_start", alu_start, 0);
        check("rst_done", cmd_done, 0);
        check("rst_err", cmd_err, 0);
        check("rst_result", result_out, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        reset = 1'b0;

        send(12'b111_011_101_010, 1);
        drain();

        send({3'b111, 3'd1, 6'd5}, 1);
        send({3'b111, 3'd2, 6'd7}, 1);
        alu_lat = 1;
        send({3'd0, 3'd4, 3'd1, 3'd2}, 1);
        drain();

        alu_lat = 3;
        send({3'd1, 3'd6, 3'd2, 3'd1}, 1);
        drain();
        alu_lat = 2;
        send({3'd2, 3'd7, 3'd4, 3'd2}, 1);
        drain();

        for (int i = 0; i < 10; i++) begin
            alu_lat = $urandom_range(1, 4);
            op = 3'($urandom_range(0, 7));
            d  = 3'($urandom_range(0, 7));
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            send({op, d, a, b}, 1);
            drain();
        end

        send({3'b111, 3'd5, 6'd9}, 1);
        alu_lat = 1;
        send({3'd0, 3'd5, 3'd5, 3'd5}, 1);
        drain();

        alu_en = 1'b0;
        send({3'd0, 3'd3, 3'd1, 3'd2}, 1);
        drain();
        alu_en = 1'b1;
`ifdef SEQ_PERF_CNT_EN
        check("abort_cnt", abort_cnt, ab_exp);
        check("retired_cnt", retired_cnt, ret_exp);
`endif
        send({3'd0, 3'd0, 3'd3, 3'd5}, 1);
        drain();

        glitch  = 1'b1;
        alu_lat = 2;
        send({3'd0, 3'd1, 3'd2, 3'd3}, 1);
        send({3'b111, 3'd6, 6'd33}, 1);
        send({3'd4, 3'd2, 3'd6, 3'd1}, 1);
        send({3'd1, 3'd7, 3'd1, 3'd6}, 1);
        drain();
        glitch = 1'b0;

        alu_en = 1'b0;
        send({3'd0, 3'd1, 3'd1, 3'd2}, 0);
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        alu_en = 1'b1;
        model_reset();
        check("rstmid_ready", cmd_ready, 1);
        check("rstmid_done", cmd_done, 0);
        check("rstmid_result", result_out, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_done) seen++;
        end
        check("rstmid_no_done", seen, 0);
        @(posedge clk);
        #1;
        alu_lat = 1;
        send({3'd0, 3'd0, 3'd1, 3'd2}, 1);
        send({3'd0, 3'd0, 3'd3, 3'd4}, 1);
        send({3'd0, 3'd0, 3'd5, 3'd6}, 1);
        send({3'd0, 3'd0, 3'd7, 3'd0}, 1);
        drain();
`ifdef SEQ_PERF_CNT_EN
        check("retired_cnt_end", retired_cnt, ret_exp);
        check("abort_cnt_end", abort_cnt, ab_exp);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
